if_id_stage_ctrl: RTL and testbench

//  PC register, IF/ID pipeline register and ID/EX control-bubble mux; consumer of the stalling unit's
//  Pc_Write / If_Id_Write / control_sel. Holds PC and IF/ID on a stall, zeroes ID/EX controls on a bubble,

---
 rtl/if_id_stage_ctrl.sv | 135 +++++++++++++
 tb/tb_if_id_stage_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_ctrl.sv
// ============================================================================
// Module   : if_id_stage_ctrl
// Brief    : PC register, IF/ID register and ID/EX bubble mux with stall/flush
//            FSM and saturating performance counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 8,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Pc_Write,
  input  logic              If_Id_Write,
  input  logic              control_sel,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       instr,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [31:0]       Pc,
  output logic [31:0]       If_Id_Pc,
  output logic [31:0]       If_Id_Instr,
  output logic              If_Id_Valid,
  output logic [CTRL_W-1:0] Id_Ex_Ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        state
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_pc;
  logic [31:0]       r_if_id_pc;
  logic [31:0]       r_if_id_instr;
  logic              r_if_id_valid;
  logic [CTRL_W-1:0] r_id_ex_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_stall;
  logic w_accept_br;

  // A branch is only honoured when it is real and the pipe is moving.
  assign w_stall     = ~Pc_Write | ~If_Id_Write;
  assign w_accept_br = branch_taken & r_if_id_valid & ~w_stall;

  always_comb begin
    w_state_nxt = RUN;
    if (w_accept_br)
      w_state_nxt = FLUSH;
    else if (w_stall)
      w_state_nxt = STALL;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= RUN;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (Pc_Write) begin
      if (w_accept_br)
        r_pc <= {branch_target[31:2], 2'b00};
      else
        r_pc <= r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= C_NOP;
      r_if_id_valid <= 1'b0;
    end else if (If_Id_Write) begin
      if (w_accept_br) begin
        r_if_id_pc    <= 32'h0;
        r_if_id_instr <= C_NOP;
        r_if_id_valid <= 1'b0;
      end else begin
        r_if_id_pc    <= r_pc;
        r_if_id_instr <= instr;
        r_if_id_valid <= 1'b1;
      end
    end
  end

  // The branch instruction itself still travels into EX on a redirect.
  always_ff @(posedge clk) begin
    if (reset)
      r_id_ex_ctrl <= '0;
    else if (!control_sel || !r_if_id_valid)
      r_id_ex_ctrl <= '0;
    else
      r_id_ex_ctrl <= ctrl_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!Pc_Write && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_accept_br && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign Pc          = r_pc;
  assign If_Id_Pc    = r_if_id_pc;
  assign If_Id_Instr = r_if_id_instr;
  assign If_Id_Valid = r_if_id_valid;
  assign Id_Ex_Ctrl  = r_id_ex_ctrl;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage_ctrl.sv
// ============================================================================
// Module   : tb_if_id_stage_ctrl
// Brief    : Directed self-checking bench for if_id_stage_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_stage_ctrl;

  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        Pc_Write, If_Id_Write, control_sel, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [7:0]  ctrl_in;

  logic [31:0] Pc, If_Id_Pc, If_Id_Instr;
  logic        If_Id_Valid;
  logic [7:0]  Id_Ex_Ctrl;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  state;

  logic [31:0] s_Pc, s_If_Id_Pc, s_If_Id_Instr;
  logic        s_If_Id_Valid;
  logic [7:0]  s_Id_Ex_Ctrl;
  logic [3:0]  s_stall_cnt, s_flush_cnt;
  logic [1:0]  s_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instruction memory model: data is a simple function of the fetch address.
  assign instr = Pc ^ K;

  if_id_stage_ctrl #(.RESET_PC(32'h0), .CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Pc_Write(Pc_Write), .If_Id_Write(If_Id_Write),
    .control_sel(control_sel), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr(instr), .ctrl_in(ctrl_in),
    .Pc(Pc), .If_Id_Pc(If_Id_Pc), .If_Id_Instr(If_Id_Instr),
    .If_Id_Valid(If_Id_Valid), .Id_Ex_Ctrl(Id_Ex_Ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  if_id_stage_ctrl #(.RESET_PC(32'h0), .CTRL_W(8), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .Pc_Write(Pc_Write), .If_Id_Write(If_Id_Write),
    .control_sel(control_sel), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr(instr), .ctrl_in(ctrl_in),
    .Pc(s_Pc), .If_Id_Pc(s_If_Id_Pc), .If_Id_Instr(s_If_Id_Instr),
    .If_Id_Valid(s_If_Id_Valid), .Id_Ex_Ctrl(s_Id_Ex_Ctrl),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ifpc,
                         input logic [31:0] ins, input logic vld, input logic [7:0] ctl,
                         input logic [15:0] sc, input logic [15:0] fc, input logic [1:0] st);
    chk({tag, ".Pc"},          Pc,                   pc);
    chk({tag, ".If_Id_Pc"},    If_Id_Pc,             ifpc);
    chk({tag, ".If_Id_Instr"}, If_Id_Instr,          ins);
    chk({tag, ".If_Id_Valid"}, {31'h0, If_Id_Valid}, {31'h0, vld});
    chk({tag, ".Id_Ex_Ctrl"},  {24'h0, Id_Ex_Ctrl},  {24'h0, ctl});
    chk({tag, ".stall_cnt"},   {16'h0, stall_cnt},   {16'h0, sc});
    chk({tag, ".flush_cnt"},   {16'h0, flush_cnt},   {16'h0, fc});
    chk({tag, ".state"},       {30'h0, state},       {30'h0, st});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic iw, input logic cs, input logic bt);
    Pc_Write     = pw;
    If_Id_Write  = iw;
    control_sel  = cs;
    branch_taken = bt;
  endtask

  initial begin
    reset = 1'b1;
    branch_target = 32'h0;
    ctrl_in = 8'hFF;
    drive(1'b0, 1'b1, 1'b1, 1'b1);

    // Reset held three cycles with hostile inputs.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset", 32'h0, 32'h0, NOP, 1'b0, 8'h00, 16'd0, 16'd0, 2'd0);
    end

    reset = 1'b0;
    ctrl_in = 8'h5A;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("first", 32'h4, 32'h0, 32'h0 ^ K, 1'b1, 8'h00, 16'd0, 16'd0, 2'd0);
    step();
    chk_all("run2", 32'h8, 32'h4, 32'h4 ^ K, 1'b1, 8'h5A, 16'd0, 16'd0, 2'd0);
    step();
    step();
    chk("run4.Pc", Pc, 32'h10);

    // One-cycle stall with bubble at Pc=0x10.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("stall", 32'h10, 32'hC, 32'hC ^ K, 1'b1, 8'h00, 16'd1, 16'd0, 2'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("unstall", 32'h14, 32'h10, 32'h10 ^ K, 1'b1, 8'h5A, 16'd1, 16'd0, 2'd0);
    for (int i = 0; i < 4; i++) step();
    chk("prebr.If_Id_Pc", If_Id_Pc, 32'h20);

    // Taken branch from ID, target with low bits set.
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    ctrl_in = 8'hC3;
    step();
    chk_all("flush", 32'h100, 32'h0, NOP, 1'b0, 8'hC3, 16'd1, 16'd1, 2'd2);
    // branch_taken still high but IF/ID is invalid: must be ignored.
    step();
    chk_all("postflush", 32'h104, 32'h100, 32'h100 ^ K, 1'b1, 8'h00, 16'd1, 16'd1, 2'd0);

    // Branch while PC is held: no redirect, no count.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk_all("br_stall", 32'h104, 32'h104, 32'h104 ^ K, 1'b1, 8'hC3, 16'd2, 16'd1, 2'd1);
    // IF/ID held while PC advances independently.
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("ifid_hold", 32'h108, 32'h104, 32'h104 ^ K, 1'b1, 8'hC3, 16'd2, 16'd1, 2'd1);

    // Reset while in STALL.
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk_all("rst_stall", 32'h0, 32'h0, NOP, 1'b0, 8'h00, 16'd0, 16'd0, 2'd0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    step();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0200;
    step();
    chk_all("flush2", 32'h200, 32'h0, NOP, 1'b0, 8'hC3, 16'd0, 16'd1, 2'd2);
    // Reset while in FLUSH.
    reset = 1'b1;
    step();
    chk_all("rst_flush", 32'h0, 32'h0, NOP, 1'b0, 8'h00, 16'd0, 16'd0, 2'd0);

    // Saturation of the narrow stall counter.
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("sat.small", {28'h0, s_stall_cnt}, (i > 15) ? 32'd15 : i);
    end
    chk("sat.wide", {16'h0, stall_cnt}, 32'd20);
    chk("sat.Pc", Pc, 32'h0);
    chk("sat.state", {30'h0, state}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("sat.hold", {28'h0, s_stall_cnt}, 32'd15);
    chk("sat.wide_hold", {16'h0, stall_cnt}, 32'd20);
    chk("sat.run", {30'h0, state}, 32'd0);
    chk("sat.Pc_adv", Pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
